// File: rtl/qdr_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qdr_pkg
// Brief    : Shared parameter checks, lane-width helper and port FSM states
// Revision : 1.0 - initial release
// ============================================================================
package qdr_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    function automatic bit burst_len_ok(input int bl);
        return (bl == 2) || (bl == 4);
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= 2) && (lat <= 8);
    endfunction

    function automatic bit lanes_ok(input int dw, input int bw);
        return (bw > 0) && ((dw % bw) == 0);
    endfunction

    function automatic int lane_width(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qdr_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : qdr_sram_responder_if
// Brief    : QDRII+ command/data bus between controller (master) and SRAM (slave)
// Revision : 1.0 - initial release
// ============================================================================
interface qdr_sram_responder_if #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 9,
    parameter int ADDR_WIDTH = 10
);
    logic                  qdriip_w_n;
    logic [ADDR_WIDTH-1:0] qdriip_wa;
    logic                  qdriip_r_n;
    logic [ADDR_WIDTH-1:0] qdriip_ra;
    logic [DATA_WIDTH-1:0] qdriip_d;
    logic [BW_WIDTH-1:0]   qdriip_bw_n;
    logic [DATA_WIDTH-1:0] qdriip_q;
    logic                  qdriip_qvld;
    logic                  protocol_err;

    modport master (
        output qdriip_w_n, qdriip_wa, qdriip_r_n, qdriip_ra, qdriip_d, qdriip_bw_n,
        input  qdriip_q, qdriip_qvld, protocol_err
    );

    modport slave (
        input  qdriip_w_n, qdriip_wa, qdriip_r_n, qdriip_ra, qdriip_d, qdriip_bw_n,
        output qdriip_q, qdriip_qvld, protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/qdr_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : qdr_resp_ram
// Brief    : Simple dual-port array, per-lane write enables, read-before-write
// Revision : 1.0 - initial release
// ============================================================================
module qdr_resp_ram
    import qdr_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 9,
    parameter int WORD_W     = 11
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic [BW_WIDTH-1:0]   we_i,
    input  wire logic [WORD_W-1:0]     waddr_i,
    input  wire logic [DATA_WIDTH-1:0] wdata_i,
    input  wire logic                  re_i,
    input  wire logic [WORD_W-1:0]     raddr_i,
    output logic      [DATA_WIDTH-1:0] rdata_o
);
    localparam int LANE_W = lane_width(DATA_WIDTH, BW_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [2**WORD_W];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < BW_WIDTH; l++) begin
            if (we_i[l]) begin
                mem_q[waddr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
            end
        end
    end

    // Separate non-blocking read sees the pre-write contents on a collision
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/qdr_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qdr_sram_responder
// Brief    : QDRII+ SRAM responder with independent read/write burst ports
// Revision : 1.0 - initial release
// ============================================================================
module qdr_sram_responder
    import qdr_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_LEN  = 2,
    parameter int RD_LAT     = 3
) (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    qdr_sram_responder_if.slave bus
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int WORD_W = ADDR_WIDTH + BEAT_W;
    localparam int DLY_N  = RD_LAT - 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    if (!burst_len_ok(BURST_LEN) || !rd_lat_ok(RD_LAT) || !lanes_ok(DATA_WIDTH, BW_WIDTH))
    begin : g_bad_params
        $error("qdr_sram_responder: illegal BURST_LEN, RD_LAT or BW_WIDTH");
    end

    logic [0:0]            w_state_q, w_state_d, r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [BEAT_W-1:0]     w_beat_q, w_beat_d, r_beat_q, r_beat_d;
    logic                  w_last, w_start, w_err, r_last, r_start, r_err;
    logic                  err_q, rv_q;
    logic [BW_WIDTH-1:0]   ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A command is only legal while idle or on the final beat of the current burst
    always_comb begin
        w_last    = (w_state_q == ST_BURST) && (w_beat_q == LAST_BEAT);
        w_start   = !bus.qdriip_w_n && ((w_state_q == ST_IDLE) || w_last);
        w_err     = !bus.qdriip_w_n && !w_start;
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_beat_d  = w_beat_q;
        if (w_start) begin
            w_state_d = ST_BURST;
            w_addr_d  = bus.qdriip_wa;
            w_beat_d  = '0;
        end else if (w_last) begin
            w_state_d = ST_IDLE;
            w_beat_d  = '0;
        end else if (w_state_q == ST_BURST) begin
            w_beat_d  = w_beat_q + BEAT_W'(1);
        end
    end

    always_comb begin
        r_last    = (r_state_q == ST_BURST) && (r_beat_q == LAST_BEAT);
        r_start   = !bus.qdriip_r_n && ((r_state_q == ST_IDLE) || r_last);
        r_err     = !bus.qdriip_r_n && !r_start;
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_beat_d  = r_beat_q;
        if (r_start) begin
            r_state_d = ST_BURST;
            r_addr_d  = bus.qdriip_ra;
            r_beat_d  = '0;
        end else if (r_last) begin
            r_state_d = ST_IDLE;
            r_beat_d  = '0;
        end else if (r_state_q == ST_BURST) begin
            r_beat_d  = r_beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_state_q <= ST_IDLE;
            w_addr_q  <= '0;
            w_beat_q  <= '0;
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_beat_q  <= '0;
            err_q     <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_beat_q  <= w_beat_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_beat_q  <= r_beat_d;
            err_q     <= err_q | w_err | r_err;
            rv_q      <= (r_state_q == ST_BURST);
        end
    end

    assign ram_we = (w_state_q == ST_BURST) ? ~bus.qdriip_bw_n : '0;

    qdr_resp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .BW_WIDTH   (BW_WIDTH),
        .WORD_W     (WORD_W)
    ) u_ram (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .we_i    (ram_we),
        .waddr_i ({w_addr_q, w_beat_q}),
        .wdata_i (bus.qdriip_d),
        .re_i    (r_state_q == ST_BURST),
        .raddr_i ({r_addr_q, r_beat_q}),
        .rdata_o (ram_rdata)
    );

    // Stages only load on a valid beat so q holds the last returned word
    if (DLY_N > 0) begin : g_dly
        logic [DATA_WIDTH-1:0] dly_data_q [DLY_N];
        logic [DLY_N-1:0]      dly_vld_q;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                dly_vld_q <= '0;
                for (int i = 0; i < DLY_N; i++) begin
                    dly_data_q[i] <= '0;
                end
            end else begin
                dly_vld_q[0] <= rv_q;
                if (rv_q) begin
                    dly_data_q[0] <= ram_rdata;
                end
                for (int i = 1; i < DLY_N; i++) begin
                    dly_vld_q[i] <= dly_vld_q[i-1];
                    if (dly_vld_q[i-1]) begin
                        dly_data_q[i] <= dly_data_q[i-1];
                    end
                end
            end
        end

        assign bus.qdriip_q    = dly_data_q[DLY_N-1];
        assign bus.qdriip_qvld = dly_vld_q[DLY_N-1];
    end else begin : g_no_dly
        assign bus.qdriip_q    = ram_rdata;
        assign bus.qdriip_qvld = rv_q;
    end

    assign bus.protocol_err = err_q;
endmodule
`default_nettype wire
